// File: rtl/trig_gen.sv
// trig_gen: qualifies a comparator result (edge + N consecutive samples) into a one-cycle trigger with holdoff,
// single-shot arming and a saturating trigger count.
module trig_gen #(
  parameter int QUAL_W = 8,
  parameter int HOLD_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmp_in,
  input  logic              en,
  input  logic              single,
  input  logic              arm,
  input  logic [QUAL_W-1:0] qual_len,
  input  logic [HOLD_W-1:0] holdoff,
  input  logic              cnt_clr,
  output logic              trig,
  output logic              armed,
  output logic              busy,
  output logic [CNT_W-1:0]  trig_cnt
);
  typedef enum logic [1:0] {IDLE, WAIT_LOW, QUAL, HOLD} state_t;
  state_t state, state_nxt;
  logic [QUAL_W-1:0] run, run_nxt;
  logic [HOLD_W-1:0] hold, hold_nxt;
  logic [QUAL_W:0] need;
  logic go, fire, qual_done;
  assign go        = en && (!single || armed);
  assign need      = (qual_len == '0) ? (QUAL_W+1)'(1) : {1'b0, qual_len};
  assign qual_done = ({1'b0, run} + (QUAL_W+1)'(1)) >= need;
  assign busy      = state == HOLD;
  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    hold_nxt  = hold;
    fire      = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
      run_nxt   = '0;
    end else begin
      case (state)
        IDLE:     state_nxt = go ? WAIT_LOW : IDLE;
        WAIT_LOW: begin
          state_nxt = !go ? IDLE : (!cmp_in ? QUAL : WAIT_LOW);
          run_nxt   = '0;
        end
        QUAL: begin
          if (!go) begin
            state_nxt = IDLE;
            run_nxt   = '0;
          end else if (cmp_in && qual_done) begin
            fire      = 1'b1;
            hold_nxt  = holdoff;
            state_nxt = HOLD;
            run_nxt   = '0;
          end else begin
            run_nxt = cmp_in ? run + QUAL_W'(1) : '0;
          end
        end
        HOLD: begin
          state_nxt = (hold == '0) ? IDLE : HOLD;
          hold_nxt  = (hold == '0) ? hold : hold - HOLD_W'(1);
        end
        default: state_nxt = IDLE;
      endcase
    end
  end
  // arm wins over the clearing trigger; clear wins over the count increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      run      <= '0;
      hold     <= '0;
      trig     <= 1'b0;
      armed    <= 1'b0;
      trig_cnt <= '0;
    end else begin
      state    <= state_nxt;
      run      <= run_nxt;
      hold     <= hold_nxt;
      trig     <= fire;
      armed    <= (single && arm) ? 1'b1 : (fire && single) ? 1'b0 : armed;
      trig_cnt <= cnt_clr ? '0 : (fire && !(&trig_cnt)) ? trig_cnt + CNT_W'(1) : trig_cnt;
    end
  end
endmodule
